// File: rtl/alu_arb_if.sv
// ---------------------------------------------------------------------------
// alu_arb_if
//   Bundle of the two requester handshakes/operand buses and the shared
//   result/flag return path of alu_arbiter.
//   master : requester side (drives req/op/a/b, observes grant/done/result)
//   slave  : arbiter side   (observes req/op/a/b, drives grant/done/result)
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface alu_arb_if #(
  parameter int WIDTH = 8
);
  logic             req0;
  logic [2:0]       op0;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] b0;
  logic             req1;
  logic [2:0]       op1;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  logic [1:0]       grant;
  logic [1:0]       done;
  logic             busy;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             zero;

  modport master (
    output req0, op0, a0, b0, req1, op1, a1, b1,
    input  grant, done, busy, result, carry, zero
  );

  modport slave (
    input  req0, op0, a0, b0, req1, op1, a1, b1,
    output grant, done, busy, result, carry, zero
  );
endinterface

`default_nettype wire

// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//   Shares one ALU between two requesters. Round-robin arbitration in IDLE,
//   operand capture, fixed 3-cycle IDLE->EXEC->DONE sequence, registered
//   result with carry/zero flags.
// Ports:
//   clk    : system clock, all logic on posedge
//   rst_n  : synchronous active-low reset
//   bus    : alu_arb_if.slave - req0/op0/a0/b0, req1/op1/a1/b1 inputs;
//            grant[1:0], done[1:0], busy, result, carry, zero outputs
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module alu_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic   clk,
  input  logic   rst_n,
  alu_arb_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_INC = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_AND = 3'b101;

  // state and captured operation
  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             owner_q, owner_d;
  logic             rr_last_q, rr_last_d;

  // registered outputs
  logic [1:0]       grant_q, grant_d;
  logic [1:0]       done_q, done_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;

  // result computed in EXEC, published in DONE
  logic [WIDTH-1:0] pend_res_q, pend_res_d;
  logic             pend_carry_q, pend_carry_d;
  logic             pend_zero_q, pend_zero_d;

  // ALU datapath, fed only from the captured registers
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   inc_ext;
  logic [WIDTH:0]   sub_ext;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;
  logic             alu_zero;

  // arbitration winner index
  logic             win;

  always_comb begin
    sum_ext   = {1'b0, a_q} + {1'b0, b_q};
    inc_ext   = {1'b0, a_q} + {{WIDTH{1'b0}}, 1'b1};
    // the extension bit of an unsigned difference is the borrow (A < B)
    sub_ext   = {1'b0, a_q} - {1'b0, b_q};
    alu_res   = '0;
    alu_carry = 1'b0;
    case (op_q)
      OP_ADD: begin
        alu_res   = sum_ext[WIDTH-1:0];
        alu_carry = sum_ext[WIDTH];
      end
      OP_INC: begin
        alu_res   = inc_ext[WIDTH-1:0];
        alu_carry = inc_ext[WIDTH];
      end
      OP_SUB: begin
        alu_res   = sub_ext[WIDTH-1:0];
        alu_carry = sub_ext[WIDTH];
      end
      OP_XOR:  alu_res = a_q ^ b_q;
      OP_OR:   alu_res = a_q | b_q;
      OP_AND:  alu_res = a_q & b_q;
      default: alu_res = '0;
    endcase
  end

  assign alu_zero = (alu_res == '0);

  // Lone requester always wins; on a tie the one not served last wins.
  assign win = bus.req1 & (~bus.req0 | ~rr_last_q);

  // next-state / output logic
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    owner_d      = owner_q;
    rr_last_d    = rr_last_q;
    grant_d      = 2'b00;
    done_d       = 2'b00;
    result_d     = result_q;
    carry_d      = carry_q;
    zero_d       = zero_q;
    pend_res_d   = pend_res_q;
    pend_carry_d = pend_carry_q;
    pend_zero_d  = pend_zero_q;

    case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          op_d        = win ? bus.op1 : bus.op0;
          a_d         = win ? bus.a1  : bus.a0;
          b_d         = win ? bus.b1  : bus.b0;
          owner_d     = win;
          rr_last_d   = win;
          grant_d     = win ? 2'b10 : 2'b01;
          state_d     = EXEC;
        end
      end
      EXEC: begin
        pend_res_d   = alu_res;
        pend_carry_d = alu_carry;
        pend_zero_d  = alu_zero;
        state_d      = DONE;
      end
      DONE: begin
        result_d = pend_res_q;
        carry_d  = pend_carry_q;
        zero_d   = pend_zero_q;
        done_d   = owner_q ? 2'b10 : 2'b01;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // registered together with the state so it tracks it exactly
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      owner_q      <= 1'b0;
      rr_last_q    <= 1'b1;  // requester 0 wins the first tie
      grant_q      <= 2'b00;
      done_q       <= 2'b00;
      busy_q       <= 1'b0;
      result_q     <= '0;
      carry_q      <= 1'b0;
      zero_q       <= 1'b0;
      pend_res_q   <= '0;
      pend_carry_q <= 1'b0;
      pend_zero_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      owner_q      <= owner_d;
      rr_last_q    <= rr_last_d;
      grant_q      <= grant_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
      result_q     <= result_d;
      carry_q      <= carry_d;
      zero_q       <= zero_d;
      pend_res_q   <= pend_res_d;
      pend_carry_q <= pend_carry_d;
      pend_zero_q  <= pend_zero_d;
    end
  end

  assign bus.grant  = grant_q;
  assign bus.done   = done_q;
  assign bus.busy   = busy_q;
  assign bus.result = result_q;
  assign bus.carry  = carry_q;
  assign bus.zero   = zero_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
//   Directed, table-driven bench for alu_arbiter plus hand-written sequences
//   for reset abort, fairness and held-request cases.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_alu_arbiter;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  logic [7:0] prev_res;

  alu_arb_if #(.WIDTH(8)) bus ();

  alu_arbiter #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         who;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       c;
    logic       z;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge. Requests, checks grant timing, scrambles the
  // requester's inputs during EXEC, then checks the done cycle.
  task automatic do_op(input int idx);
    vec_t v;
    logic [1:0] oh;
    v  = vecs[idx];
    oh = (v.who == 0) ? 2'b01 : 2'b10;
    if (v.who == 0) begin
      bus.req0 = 1'b1; bus.op0 = v.op; bus.a0 = v.a; bus.b0 = v.b;
    end else begin
      bus.req1 = 1'b1; bus.op1 = v.op; bus.a1 = v.a; bus.b1 = v.b;
    end
    @(negedge clk);
    chk($sformatf("v%0d_grant", idx), {30'd0, bus.grant}, {30'd0, oh});
    chk($sformatf("v%0d_busy_exec", idx), {31'd0, bus.busy}, 32'd1);
    chk($sformatf("v%0d_done_exec", idx), {30'd0, bus.done}, 32'd0);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    bus.op0 = ~v.op; bus.a0 = ~v.a; bus.b0 = v.b + 8'd77;
    bus.op1 = ~v.op; bus.a1 = ~v.a; bus.b1 = v.b + 8'd77;
    @(negedge clk);
    chk($sformatf("v%0d_grant_off", idx), {30'd0, bus.grant}, 32'd0);
    chk($sformatf("v%0d_res_held", idx), {24'd0, bus.result}, {24'd0, prev_res});
    chk($sformatf("v%0d_busy_done", idx), {31'd0, bus.busy}, 32'd1);
    @(negedge clk);
    chk($sformatf("v%0d_done", idx), {30'd0, bus.done}, {30'd0, oh});
    chk($sformatf("v%0d_result", idx), {24'd0, bus.result}, {24'd0, v.res});
    chk($sformatf("v%0d_carry", idx), {31'd0, bus.carry}, {31'd0, v.c});
    chk($sformatf("v%0d_zero", idx), {31'd0, bus.zero}, {31'd0, v.z});
    chk($sformatf("v%0d_busy_idle", idx), {31'd0, bus.busy}, 32'd0);
    chk($sformatf("v%0d_grant_idle", idx), {30'd0, bus.grant}, 32'd0);
    prev_res = v.res;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //             who op      a      b      res    c     z
    vecs[0]  = '{0, 3'b000, 8'd200, 8'd100, 8'd44,  1'b1, 1'b0};
    vecs[1]  = '{1, 3'b010, 8'd5,   8'd9,   8'd252, 1'b1, 1'b0};
    vecs[2]  = '{1, 3'b010, 8'd9,   8'd9,   8'd0,   1'b0, 1'b1};
    vecs[3]  = '{0, 3'b001, 8'd255, 8'd7,   8'd0,   1'b1, 1'b1};
    vecs[4]  = '{0, 3'b100, 8'hA0,  8'h05,  8'hA5,  1'b0, 1'b0};
    vecs[5]  = '{0, 3'b110, 8'hFF,  8'hFF,  8'h00,  1'b0, 1'b1};
    vecs[6]  = '{0, 3'b111, 8'h12,  8'h34,  8'h00,  1'b0, 1'b1};
    vecs[7]  = '{1, 3'b101, 8'hF0,  8'h3C,  8'h30,  1'b0, 1'b0};
    vecs[8]  = '{0, 3'b011, 8'hAA,  8'hAA,  8'h00,  1'b0, 1'b1};
    vecs[9]  = '{1, 3'b000, 8'h01,  8'h02,  8'h03,  1'b0, 1'b0};
    vecs[10] = '{0, 3'b010, 8'd200, 8'd100, 8'd100, 1'b0, 1'b0};

    total = 0;
    bad = 0;
    prev_res = 8'd0;
    rst_n = 1'b0;
    bus.req0 = 1'b0; bus.op0 = 3'b0; bus.a0 = 8'd0; bus.b0 = 8'd0;
    bus.req1 = 1'b0; bus.op1 = 3'b0; bus.a1 = 8'd0; bus.b1 = 8'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // reset state
    chk("rst_grant",  {30'd0, bus.grant},  32'd0);
    chk("rst_done",   {30'd0, bus.done},   32'd0);
    chk("rst_busy",   {31'd0, bus.busy},   32'd0);
    chk("rst_result", {24'd0, bus.result}, 32'd0);
    chk("rst_carry",  {31'd0, bus.carry},  32'd0);
    chk("rst_zero",   {31'd0, bus.zero},   32'd0);

    for (int i = 0; i < 11; i++) do_op(i);

    // reset during EXEC aborts the op (last owner was 0, so rr_last=0 here)
    bus.req0 = 1'b1; bus.op0 = 3'b000; bus.a0 = 8'd1; bus.b0 = 8'd2;
    @(negedge clk);
    chk("abort_grant", {30'd0, bus.grant}, 32'd1);
    bus.req0 = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_done",   {30'd0, bus.done},   32'd0);
    chk("abort_busy",   {31'd0, bus.busy},   32'd0);
    chk("abort_result", {24'd0, bus.result}, 32'd0);
    chk("abort_carry",  {31'd0, bus.carry},  32'd0);
    chk("abort_zero",   {31'd0, bus.zero},   32'd0);
    // request during reset must not be captured
    bus.req0 = 1'b1;
    @(negedge clk);
    chk("rstreq_grant", {30'd0, bus.grant}, 32'd0);
    chk("rstreq_done",  {30'd0, bus.done},  32'd0);
    rst_n = 1'b1;
    bus.req0 = 1'b0;
    @(negedge clk);
    chk("rstreq_busy",  {31'd0, bus.busy},  32'd0);
    chk("rstreq_grant2", {30'd0, bus.grant}, 32'd0);
    prev_res = 8'd0;

    // fairness: both requesting, first tie after reset goes to 0
    bus.op0 = 3'b011; bus.a0 = 8'hF0; bus.b0 = 8'h3C;
    bus.op1 = 3'b101; bus.a1 = 8'hF0; bus.b1 = 8'h3C;
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    for (int g = 0; g < 4; g++) begin
      @(negedge clk);
      chk($sformatf("rr%0d_grant", g), {30'd0, bus.grant}, (g % 2 == 0) ? 32'd1 : 32'd2);
      if (g % 2 == 0) bus.req0 = 1'b0; else bus.req1 = 1'b0;
      @(negedge clk);
      chk($sformatf("rr%0d_mid", g), {30'd0, bus.done | bus.grant}, 32'd0);
      @(negedge clk);
      chk($sformatf("rr%0d_done", g), {30'd0, bus.done}, (g % 2 == 0) ? 32'd1 : 32'd2);
      chk($sformatf("rr%0d_result", g), {24'd0, bus.result}, (g % 2 == 0) ? 32'hCC : 32'h30);
      if (g % 2 == 0) bus.req0 = 1'b1; else bus.req1 = 1'b1;
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);

    // req0 held past grant: second op 3 cycles after first grant
    bus.op0 = 3'b100; bus.a0 = 8'h0F; bus.b0 = 8'hF0;
    bus.req0 = 1'b1;
    @(negedge clk);
    chk("hold_g1", {30'd0, bus.grant}, 32'd1);
    @(negedge clk);
    chk("hold_busy_a", {31'd0, bus.busy}, 32'd1);
    @(negedge clk);
    chk("hold_done1", {30'd0, bus.done}, 32'd1);
    chk("hold_gap_busy", {31'd0, bus.busy}, 32'd0);
    chk("hold_res1", {24'd0, bus.result}, 32'hFF);
    @(negedge clk);
    chk("hold_g2", {30'd0, bus.grant}, 32'd1);
    chk("hold_busy_b", {31'd0, bus.busy}, 32'd1);
    bus.req0 = 1'b0;
    @(negedge clk);
    chk("hold_busy_c", {31'd0, bus.busy}, 32'd1);
    @(negedge clk);
    chk("hold_done2", {30'd0, bus.done}, 32'd1);
    @(negedge clk);
    chk("hold_idle_busy", {31'd0, bus.busy}, 32'd0);
    chk("hold_idle_grant", {30'd0, bus.grant}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
